seg_shift_driver: RTL and testbench

//   Parametrised successor to the single-chain 7-segment decode/shift stage of the counter display path.
//   On trigger, snapshots a packed BCD/hex count and decodes each nibble to a segment byte.

---
 rtl/seg_shift_driver.sv | 162 ++++++++++++++++
 tb/tb_seg_shift_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_shift_driver.sv
// seg_shift_driver: snapshots a packed BCD/hex count, decodes each nibble
// to a 7-segment byte (with decimal points, optional leading-zero blanking
// and output polarity), shifts the bytes MSB-first into a 595-style chain,
// then pulses the storage latch.
module seg_shift_driver #(
   parameter int DIGITS     = 6,
   parameter int CLK_DIV    = 1,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   cnt_in,
   input  logic                  trigger,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [7:0]            segOut,
   output logic                  shiftOut,
   output logic                  shift_clk,
   output logic                  latch,
   output logic                  busy,
   output logic                  done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

   state_t                   state_q, state_d;
   logic [DW-1:0]            div_q, div_d;
   logic [GW-1:0]            digit_q, digit_d;
   logic [2:0]               bit_q, bit_d;
   logic [DIGITS-1:0][7:0]   bytes_q, bytes_d;
   logic [7:0]               seg_q, seg_d;
   logic                     sout_q, sout_d;

   logic [DIGITS-1:0][7:0]   frame_w;
   logic                     div_end;
   logic                     last_bit;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      case (n)
         4'h0: dec7 = 7'h3F;  4'h1: dec7 = 7'h06;  4'h2: dec7 = 7'h5B;  4'h3: dec7 = 7'h4F;
         4'h4: dec7 = 7'h66;  4'h5: dec7 = 7'h6D;  4'h6: dec7 = 7'h7D;  4'h7: dec7 = 7'h07;
         4'h8: dec7 = 7'h7F;  4'h9: dec7 = 7'h6F;  4'hA: dec7 = 7'h77;  4'hB: dec7 = 7'h7C;
         4'hC: dec7 = 7'h39;  4'hD: dec7 = 7'h5E;  4'hE: dec7 = 7'h79;  default: dec7 = 7'h71;
      endcase
   endfunction

   // Decode the live inputs into final frame bytes; only latched on trigger.
   // Blanking walks down from the top digit until the first nonzero nibble;
   // digit 0 always shows so an all-zero count still reads "0".
   always_comb begin
      logic       lead;
      logic [3:0] nib;
      logic [7:0] b;
      frame_w = '0;
      lead    = blank_lz;
      nib     = 4'h0;
      b       = 8'h00;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = cnt_in[4*i +: 4];
         if (lead && (i != 0) && (nib == 4'h0)) begin
            b = 8'h00;
         end else begin
            b    = {1'b0, dec7(nib)};
            lead = 1'b0;
         end
         frame_w[i] = (b | {dp_mask[i], 7'b0}) ^ {8{ACTIVE_LOW}};
      end
   end

   assign div_end  = (div_q == DW'(CLK_DIV - 1));
   assign last_bit = (digit_q == '0) && (bit_q == 3'd0);

   // Next-state: frame start, shift-clock phase timing and bit/digit advance.
   // Data only moves on the high->low shift_clk transition so it is stable
   // across every rising edge seen by the chain.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      digit_d = digit_q;
      bit_d   = bit_q;
      bytes_d = bytes_q;
      seg_d   = seg_q;
      sout_d  = sout_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (trigger) begin
               state_d = SHIFT_LO;
               bytes_d = frame_w;
               digit_d = GW'(DIGITS - 1);
               bit_d   = 3'd7;
               seg_d   = frame_w[DIGITS-1];
               sout_d  = frame_w[DIGITS-1][7];
               div_d   = '0;
            end
         end
         SHIFT_LO: begin
            if (div_end) begin
               div_d   = '0;
               state_d = SHIFT_HI;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         SHIFT_HI: begin
            if (div_end) begin
               div_d = '0;
               if (last_bit) begin
                  state_d = LATCH;
               end else begin
                  state_d = SHIFT_LO;
                  if (bit_q == 3'd0) begin
                     digit_d = digit_q - GW'(1);
                     bit_d   = 3'd7;
                     seg_d   = bytes_q[digit_q - GW'(1)];
                     sout_d  = bytes_q[digit_q - GW'(1)][7];
                  end else begin
                     bit_d  = bit_q - 3'd1;
                     sout_d = seg_q[bit_q - 3'd1];
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         LATCH:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any snapshot in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         digit_q <= '0;
         bit_q   <= 3'd0;
         bytes_q <= '0;
         seg_q   <= 8'h00;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         digit_q <= digit_d;
         bit_q   <= bit_d;
         bytes_q <= bytes_d;
         seg_q   <= seg_d;
         sout_q  <= sout_d;
      end
   end

   assign segOut    = seg_q;
   assign shiftOut  = sout_q;
   assign shift_clk = (state_q == SHIFT_HI);
   assign latch     = (state_q == LATCH);
   assign busy      = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LATCH);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seg_shift_driver.sv
// Directed bench for seg_shift_driver: three instances cover the default
// configuration, inverted polarity and a divided shift clock.
module tb_seg_shift_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] cnt_in;
   logic        blank_lz;
   logic [5:0]  dp_mask;
   logic [2:0]  trig;
   logic [7:0]  seg0, seg1, seg2;
   logic [2:0]  so, sck, lat, bsy, dn;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_shift_driver #(.DIGITS(6), .CLK_DIV(1), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .trigger(trig[0]), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .segOut(seg0), .shiftOut(so[0]), .shift_clk(sck[0]),
      .latch(lat[0]), .busy(bsy[0]), .done(dn[0]));

   seg_shift_driver #(.DIGITS(6), .CLK_DIV(1), .ACTIVE_LOW(1'b1)) u_al (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .trigger(trig[1]), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .segOut(seg1), .shiftOut(so[1]), .shift_clk(sck[1]),
      .latch(lat[1]), .busy(bsy[1]), .done(dn[1]));

   seg_shift_driver #(.DIGITS(6), .CLK_DIV(3), .ACTIVE_LOW(1'b0)) u_div (
      .clk(clk), .reset(reset), .cnt_in(cnt_in), .trigger(trig[2]), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .segOut(seg2), .shiftOut(so[2]), .shift_clk(sck[2]),
      .latch(lat[2]), .busy(bsy[2]), .done(dn[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Trigger instance k for one cycle and watch the whole frame at negedges.
   task automatic frame(input string tag, input int k, input int div,
                        input logic [47:0] exp, input int retrig_at);
      logic [47:0] got;
      int   rises, bcyc, lats, dones, bad_seg, bad_edge, bad_w, run;
      logic psck, pso, csck, cso, cbusy, clat, cdone;
      logic [7:0] cseg;
      got = '0; rises = 0; bcyc = 0; lats = 0; dones = 0;
      bad_seg = 0; bad_edge = 0; bad_w = 0; run = 0;
      psck = 1'b0; pso = 1'b0;
      trig[k] = 1'b1;
      @(negedge clk);
      trig[k] = 1'b0;
      for (int c = 0; c < 2000 && dones == 0; c++) begin
         if (c > 0) @(negedge clk);
         if (c == retrig_at)     trig[k] = 1'b1;
         if (c == retrig_at + 1) trig[k] = 1'b0;
         case (k)
            0:       cseg = seg0;
            1:       cseg = seg1;
            default: cseg = seg2;
         endcase
         csck = sck[k]; cso = so[k]; cbusy = bsy[k]; clat = lat[k]; cdone = dn[k];
         if (c > 0) begin
            if (cso != pso && !(psck && !csck)) bad_edge++;
            if (!psck && csck) begin
               got = {got[46:0], cso};
               if (rises < 48 && cseg != exp[47 - 8*(rises/8) -: 8]) bad_seg++;
               rises++;
               if (run != div) bad_w++;
               run = 0;
            end else if (psck && !csck) begin
               if (run != div) bad_w++;
               run = 0;
            end
         end
         run++;
         if (cbusy) bcyc++;
         if (clat)  lats++;
         if (cdone) dones++;
         psck = csck; pso = cso;
      end
      chk({tag, " data"},   64'(got),      64'(exp));
      chk({tag, " rises"},  64'(rises),    64'd48);
      chk({tag, " busy"},   64'(bcyc),     64'(96*div + 1));
      chk({tag, " latch"},  64'(lats),     64'd1);
      chk({tag, " done"},   64'(dones),    64'd1);
      chk({tag, " segOut"}, 64'(bad_seg),  64'd0);
      chk({tag, " edges"},  64'(bad_edge), 64'd0);
      chk({tag, " widths"}, 64'(bad_w),    64'd0);
   endtask

   initial begin
      int rises, lats, dones, bhi;
      logic psck;
      reset = 1'b1; cnt_in = '0; blank_lz = 1'b0; dp_mask = '0; trig = '0;
      #3;
      chk("reset outs dut", {seg0, so[0], sck[0], lat[0], bsy[0], dn[0]}, '0);
      chk("reset outs al",  {seg1, so[1], sck[1], lat[1], bsy[1], dn[1]}, '0);
      chk("reset outs div", {seg2, so[2], sck[2], lat[2], bsy[2], dn[2]}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      cnt_in = 24'h654321;
      frame("basic", 0, 1, 48'h7D6D664F5B06, -5);
      chk("idle sclk", 64'(sck[0]), 64'd0);
      chk("idle seg",  64'(seg0),   64'h06);
      chk("idle so",   64'(so[0]),  64'd0);

      cnt_in = 24'hFEDCBA;
      frame("hex", 0, 1, 48'h71795E397C77, -5);
      cnt_in = 24'h654321; dp_mask = 6'b100001;
      frame("dp", 0, 1, 48'hFD6D664F5B86, -5);

      dp_mask = '0; blank_lz = 1'b1; cnt_in = 24'h000050;
      frame("blank50", 0, 1, 48'h000000006D3F, -5);
      cnt_in = 24'h000000;
      frame("blank0", 0, 1, 48'h00000000003F, -5);
      blank_lz = 1'b0; cnt_in = 24'h000050;
      frame("noblank", 0, 1, 48'h3F3F3F3F6D3F, -5);

      cnt_in = 24'h00000A; dp_mask = 6'b000010;
      frame("al", 1, 1, 48'hC0C0C0C04088, -5);
      blank_lz = 1'b1;
      frame("al blank", 1, 1, 48'hFFFFFFFF7F88, -5);

      blank_lz = 1'b0; dp_mask = '0; cnt_in = 24'h654321;
      frame("retrig", 0, 1, 48'h7D6D664F5B06, 20);
      @(negedge clk);
      chk("retrig idle", 64'(bsy[0]), 64'd0);

      // Held trigger: frames run back to back, 98 cycles apart.
      dones = 0; lats = 0; bhi = 0;
      trig[0] = 1'b1;
      for (int c = 0; c < 196; c++) begin
         @(negedge clk);
         if (dn[0])  dones++;
         if (lat[0]) lats++;
         if (bsy[0]) bhi++;
      end
      trig[0] = 1'b0;
      chk("held done",  64'(dones), 64'd2);
      chk("held latch", 64'(lats),  64'd2);
      chk("held busy",  64'(bhi),   64'd194);
      @(negedge clk);
      chk("held stop", 64'(bsy[0]), 64'd0);

      // Reset in the middle of a frame.
      cnt_in = 24'h123456;
      trig[0] = 1'b1;
      @(negedge clk);
      trig[0] = 1'b0;
      rises = 0; psck = 1'b0;
      for (int c = 0; c < 200 && rises < 20; c++) begin
         if (!psck && sck[0]) rises++;
         psck = sck[0];
         if (rises < 20) @(negedge clk);
      end
      chk("midrst reached", 64'(rises), 64'd20);
      reset = 1'b1;
      #1;
      chk("midrst outs", {seg0, so[0], sck[0], lat[0], bsy[0], dn[0]}, '0);
      lats = 0;
      repeat (2) begin
         @(negedge clk);
         if (lat[0]) lats++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (lat[0] || bsy[0]) lats++;
      end
      chk("midrst nolatch", 64'(lats), 64'd0);
      frame("after rst", 0, 1, 48'h065B4F666D7D, -5);

      frame("div3", 2, 3, 48'h065B4F666D7D, -5);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
